// File: rtl/device_ram_port_if.sv
// device_ram_port_if: bus bundle between the slot-device request aggregate,
// the device RAM port and the SDRAM arbiter auxiliary read port.
//
// Handshake: the device side raises dev_ram_cs with dev_ram_addr valid; a new
// request is any rising cs or address change while cs is high. The result
// comes back as a one-cycle dev_ram_valid strobe with dev_ram_data. On the
// SDRAM side sdram_req is a level held with sdram_addr stable until the
// one-cycle sdram_ack, which carries sdram_rdata in the same cycle.
interface device_ram_port_if #(
  parameter int ADDR_WIDTH = 27
);
  logic                  dev_ram_cs;
  logic [ADDR_WIDTH-1:0] dev_ram_addr;
  logic [7:0]            dev_ram_data;
  logic                  dev_ram_valid;
  logic                  cpu_wait;
  logic                  sdram_req;
  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic                  sdram_ack;
  logic [7:0]            sdram_rdata;
  logic                  timeout_err;

  // The port itself.
  modport slave (
    input  dev_ram_cs, dev_ram_addr, sdram_ack, sdram_rdata,
    output dev_ram_data, dev_ram_valid, cpu_wait, sdram_req, sdram_addr,
           timeout_err
  );

  // Device aggregate plus SDRAM arbiter, seen as one peer.
  modport master (
    output dev_ram_cs, dev_ram_addr, sdram_ack, sdram_rdata,
    input  dev_ram_data, dev_ram_valid, cpu_wait, sdram_req, sdram_addr,
           timeout_err
  );
endinterface

// File: rtl/device_ram_port.sv
// device_ram_port: turns device ram_cs/ram_addr requests into handshaked
// SDRAM reads, returns the byte with a one-cycle strobe and stretches the CPU
// with cpu_wait while a fetch is outstanding. A one-deep pending slot keeps
// the newest request that arrives during a fetch.
// Optional feature macro: DEVICE_RAM_CACHE_EN (one-entry read cache).
module device_ram_port #(
  parameter int ADDR_WIDTH = 27,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  device_ram_port_if.slave        bus,
  output logic [1:0]              dbg_state_o
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic                  cs_prev_q;
  logic [ADDR_WIDTH-1:0] addr_prev_q;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]            timer_q, timer_d;
  logic [7:0]            cap_q, cap_d;
  logic                  sdram_req_q, sdram_req_d;
  logic [ADDR_WIDTH-1:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  cpu_wait_q, cpu_wait_d;
  logic                  err_q, err_d;
  logic                  req_event;

`ifdef DEVICE_RAM_CACHE_EN
  logic                  cache_valid_q, cache_valid_d;
  logic [ADDR_WIDTH-1:0] cache_tag_q, cache_tag_d;
  logic [7:0]            cache_data_q, cache_data_d;
  logic                  hit_q, hit_d;
  logic                  cache_hit;
  assign cache_hit = cache_valid_q && (cache_tag_q == bus.dev_ram_addr);
`endif

  // New request: cs rising, or address moving while cs is held.
  assign req_event = bus.dev_ram_cs &&
                     (!cs_prev_q || (bus.dev_ram_addr != addr_prev_q));

  // Next-state and registered-output computation; outputs appear one edge
  // after the state that decides them.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    timer_d      = timer_q;
    cap_d        = cap_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    cpu_wait_d   = cpu_wait_q;
    err_d        = err_q;
`ifdef DEVICE_RAM_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    hit_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        sdram_req_d = 1'b0;
        cpu_wait_d  = 1'b0;
        if (req_event) begin
`ifdef DEVICE_RAM_CACHE_EN
          if (cache_hit) begin
            hit_d = 1'b1;
          end else begin
            state_d      = ST_REQ;
            sdram_addr_d = bus.dev_ram_addr;
          end
`else
          state_d      = ST_REQ;
          sdram_addr_d = bus.dev_ram_addr;
`endif
        end
      end
      ST_REQ: begin
        sdram_req_d = 1'b1;
        cpu_wait_d  = 1'b1;
        timer_d     = 8'd0;
        state_d     = ST_WAIT;
        if (req_event) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = bus.dev_ram_addr;
        end
      end
      ST_WAIT: begin
        sdram_req_d = 1'b1;
        cpu_wait_d  = 1'b1;
        if (req_event) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = bus.dev_ram_addr;
        end
        if (bus.sdram_ack) begin
          state_d = ST_DONE;
          cap_d   = bus.sdram_rdata;
`ifdef DEVICE_RAM_CACHE_EN
          cache_valid_d = 1'b1;
          cache_tag_d   = sdram_addr_q;
          cache_data_d  = bus.sdram_rdata;
`endif
        end else if (timer_q == TIMEOUT_CNT) begin
          state_d = ST_DONE;
          cap_d   = 8'hFF;
          err_d   = 1'b1;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DONE: begin
        sdram_req_d = 1'b0;
        valid_d     = 1'b1;
        data_d      = cap_q;
        // A request arriving on this very edge is newer than the slot.
        if (req_event) begin
          state_d      = ST_REQ;
          sdram_addr_d = bus.dev_ram_addr;
          pend_valid_d = 1'b0;
          cpu_wait_d   = 1'b1;
        end else if (pend_valid_q) begin
          state_d      = ST_REQ;
          sdram_addr_d = pend_addr_q;
          pend_valid_d = 1'b0;
          cpu_wait_d   = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          cpu_wait_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef DEVICE_RAM_CACHE_EN
    if (hit_q) begin
      valid_d = 1'b1;
      data_d  = cache_data_q;
    end
`endif
  end

  // State and output registers; reset drops any fetch or pending request.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b0;
      addr_prev_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      timer_q      <= 8'd0;
      cap_q        <= 8'hFF;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      data_q       <= 8'hFF;
      valid_q      <= 1'b0;
      cpu_wait_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef DEVICE_RAM_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= 8'hFF;
      hit_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= bus.dev_ram_cs;
      addr_prev_q  <= bus.dev_ram_addr;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      timer_q      <= timer_d;
      cap_q        <= cap_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      cpu_wait_q   <= cpu_wait_d;
      err_q        <= err_d;
`ifdef DEVICE_RAM_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      hit_q         <= hit_d;
`endif
    end
  end

  assign bus.sdram_req     = sdram_req_q;
  assign bus.sdram_addr    = sdram_addr_q;
  assign bus.dev_ram_data  = data_q;
  assign bus.dev_ram_valid = valid_q;
  assign bus.cpu_wait      = cpu_wait_q;
  assign bus.timeout_err   = err_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_device_ram_port.sv
// tb_device_ram_port: directed tests for device_ram_port with TIMEOUT=8.
// Inputs are driven and outputs sampled 1ns after the falling clock edge.
module tb_device_ram_port;
  localparam int AW = 27;
  localparam int TO = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         rise_cnt = 0;
  logic       req_prev = 1'b0;
  logic [AW-1:0] rise_addr_q[$];

  device_ram_port_if #(.ADDR_WIDTH(AW)) bus ();

  device_ram_port #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset block
  always #5 clk_sys = ~clk_sys;

  // Log every rising sdram_req with its address.
  always @(negedge clk_sys) begin
    if (bus.sdram_req && !req_prev) begin
      rise_cnt++;
      rise_addr_q.push_back(bus.sdram_addr);
    end
    req_prev = bus.sdram_req;
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    bus.dev_ram_cs = 1'b0; bus.dev_ram_addr = '0;
    bus.sdram_ack = 1'b0; bus.sdram_rdata = 8'h00;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.sdram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", bus.sdram_req); end
    checks++; if (bus.sdram_addr !== 27'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.sdram_addr); end
    checks++; if (bus.dev_ram_data !== 8'hFF) begin failures++; $display("FAIL reset_data got=%0h exp=ff", bus.dev_ram_data); end
    checks++; if (bus.dev_ram_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.dev_ram_valid); end
    checks++; if (bus.cpu_wait !== 1'b0) begin failures++; $display("FAIL reset_wait got=%0h exp=0", bus.cpu_wait); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.timeout_err); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0h exp=0", dbg_state); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int hi = 0;
    bus.dev_ram_cs = 1'b1; bus.dev_ram_addr = 27'h0012345;
    tick(); // after edge N
    checks++; if (dbg_state !== S_REQ) begin failures++; $display("FAIL single_state_n got=%0h exp=1", dbg_state); end
    checks++; if (bus.sdram_req !== 1'b0) begin failures++; $display("FAIL single_req_n got=%0h exp=0", bus.sdram_req); end
    tick(); // N+1
    checks++; if (bus.sdram_req !== 1'b1) begin failures++; $display("FAIL single_req_n1 got=%0h exp=1", bus.sdram_req); end
    checks++; if (bus.sdram_addr !== 27'h0012345) begin failures++; $display("FAIL single_addr got=%0h exp=12345", bus.sdram_addr); end
    if (bus.cpu_wait) hi++;
    tick(); // N+2
    if (bus.cpu_wait) hi++;
    tick(); // N+3
    if (bus.cpu_wait) hi++;
    bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'h5A;
    tick(); // N+4 (ack sampled)
    bus.sdram_ack = 1'b0; bus.sdram_rdata = 8'h00;
    if (bus.cpu_wait) hi++;
    checks++; if (bus.sdram_req !== 1'b1) begin failures++; $display("FAIL single_req_hold got=%0h exp=1", bus.sdram_req); end
    checks++; if (bus.dev_ram_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%0h exp=0", bus.dev_ram_valid); end
    tick(); // N+5
    if (bus.cpu_wait) hi++;
    checks++; if (bus.dev_ram_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", bus.dev_ram_valid); end
    checks++; if (bus.dev_ram_data !== 8'h5A) begin failures++; $display("FAIL single_data got=%0h exp=5a", bus.dev_ram_data); end
    checks++; if (bus.sdram_req !== 1'b0) begin failures++; $display("FAIL single_req_low got=%0h exp=0", bus.sdram_req); end
    tick(); // N+6
    checks++; if (bus.dev_ram_valid !== 1'b0) begin failures++; $display("FAIL single_valid_pulse got=%0h exp=0", bus.dev_ram_valid); end
    checks++; if (hi !== 4) begin failures++; $display("FAIL single_wait_cycles got=%0d exp=4", hi); end
    bus.dev_ram_cs = 1'b0;
    tick();
  endtask

  task automatic test_stray_ack();
    int vcount = 0;
    for (int i = 0; i < 3; i++) begin
      bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'h99 + 8'(i);
      tick();
      if (bus.dev_ram_valid) vcount++;
      bus.sdram_ack = 1'b0;
      tick();
      if (bus.dev_ram_valid) vcount++;
    end
    tick();
    checks++; if (vcount !== 0) begin failures++; $display("FAIL stray_valid got=%0d exp=0", vcount); end
    checks++; if (bus.dev_ram_data !== 8'h5A) begin failures++; $display("FAIL stray_data got=%0h exp=5a", bus.dev_ram_data); end
    checks++; if (bus.sdram_addr !== 27'h0012345) begin failures++; $display("FAIL stray_addr got=%0h exp=12345", bus.sdram_addr); end
    checks++; if ({bus.sdram_req, bus.cpu_wait, bus.timeout_err} !== 3'b000) begin failures++; $display("FAIL stray_ctrl got=%0b exp=000", {bus.sdram_req, bus.cpu_wait, bus.timeout_err}); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL stray_state got=%0h exp=0", dbg_state); end
  endtask

  task automatic test_back_to_back();
    int lows = 0;
    int rise0 = rise_cnt;
    rise_addr_q.delete();
    bus.dev_ram_cs = 1'b1; bus.dev_ram_addr = 27'h100;
    tick(); // N
    tick(); // N+1
    if (!bus.cpu_wait) lows++;
    bus.dev_ram_addr = 27'h101;
    tick(); // N+2
    if (!bus.cpu_wait) lows++;
    bus.dev_ram_addr = 27'h102;
    tick(); // N+3
    if (!bus.cpu_wait) lows++;
    bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'hA1;
    tick(); // N+4
    if (!bus.cpu_wait) lows++;
    bus.sdram_ack = 1'b0;
    checks++; if (dbg_state !== S_DONE) begin failures++; $display("FAIL b2b_done got=%0h exp=3", dbg_state); end
    tick(); // N+5
    if (!bus.cpu_wait) lows++;
    checks++; if (bus.dev_ram_valid !== 1'b1 || bus.dev_ram_data !== 8'hA1) begin failures++; $display("FAIL b2b_first_data got=%0h/%0h exp=1/a1", bus.dev_ram_valid, bus.dev_ram_data); end
    checks++; if (bus.sdram_req !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%0h exp=0", bus.sdram_req); end
    tick(); // N+6
    if (!bus.cpu_wait) lows++;
    checks++; if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 27'h102) begin failures++; $display("FAIL b2b_second_req got=%0h/%0h exp=1/102", bus.sdram_req, bus.sdram_addr); end
    bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'hB2;
    tick(); // N+7
    if (!bus.cpu_wait) lows++;
    bus.sdram_ack = 1'b0;
    tick(); // N+8
    checks++; if (bus.dev_ram_valid !== 1'b1 || bus.dev_ram_data !== 8'hB2) begin failures++; $display("FAIL b2b_second_data got=%0h/%0h exp=1/b2", bus.dev_ram_valid, bus.dev_ram_data); end
    checks++; if (bus.cpu_wait !== 1'b0) begin failures++; $display("FAIL b2b_wait_end got=%0h exp=0", bus.cpu_wait); end
    checks++; if (lows !== 0) begin failures++; $display("FAIL b2b_wait_gap got=%0d exp=0", lows); end
    checks++; if (rise_cnt - rise0 !== 2) begin failures++; $display("FAIL b2b_reads got=%0d exp=2", rise_cnt - rise0); end
    checks++; if (rise_addr_q.size() != 2 || rise_addr_q[0] !== 27'h100 || rise_addr_q[1] !== 27'h102) begin failures++; $display("FAIL b2b_addrs got_n=%0d exp=100,102", rise_addr_q.size()); end
    bus.dev_ram_cs = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int k = 0;
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_before got=%0h exp=0", bus.timeout_err); end
    bus.dev_ram_cs = 1'b1; bus.dev_ram_addr = 27'h300;
    tick(); // N
    tick(); // N+1, sdram_req rises
    checks++; if (bus.sdram_req !== 1'b1) begin failures++; $display("FAIL to_req got=%0h exp=1", bus.sdram_req); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.dev_ram_valid) begin k = i; break; end
    end
    checks++; if (k !== TO + 2) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", k, TO + 2); end
    checks++; if (bus.dev_ram_data !== 8'hFF) begin failures++; $display("FAIL to_data got=%0h exp=ff", bus.dev_ram_data); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%0h exp=1", bus.timeout_err); end
    bus.dev_ram_cs = 1'b0;
    repeat (3) tick();
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0h exp=1", bus.timeout_err); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL to_idle got=%0h exp=0", dbg_state); end
  endtask

  task automatic test_reset_mid();
    int vcount = 0;
    bus.dev_ram_cs = 1'b1; bus.dev_ram_addr = 27'h400;
    repeat (3) tick();
    checks++; if (dbg_state !== S_WAIT) begin failures++; $display("FAIL rmid_wait got=%0h exp=2", dbg_state); end
    reset_n = 1'b0; bus.dev_ram_cs = 1'b0;
    tick();
    checks++; if ({bus.sdram_req, bus.cpu_wait, bus.dev_ram_valid, bus.timeout_err} !== 4'b0000) begin failures++; $display("FAIL rmid_ctrl got=%0b exp=0000", {bus.sdram_req, bus.cpu_wait, bus.dev_ram_valid, bus.timeout_err}); end
    checks++; if (bus.dev_ram_data !== 8'hFF || bus.sdram_addr !== 27'h0) begin failures++; $display("FAIL rmid_regs got=%0h/%0h exp=ff/0", bus.dev_ram_data, bus.sdram_addr); end
    reset_n = 1'b1;
    tick();
    bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'h77;
    tick();
    bus.sdram_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.dev_ram_valid) vcount++;
    end
    checks++; if (vcount !== 0) begin failures++; $display("FAIL rmid_valid got=%0d exp=0", vcount); end
    checks++; if (dbg_state !== S_IDLE || bus.sdram_req !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%0h/%0h exp=0/0", dbg_state, bus.sdram_req); end
    checks++; if (bus.dev_ram_data !== 8'hFF) begin failures++; $display("FAIL rmid_data got=%0h exp=ff", bus.dev_ram_data); end
  endtask

`ifdef DEVICE_RAM_CACHE_EN
  task automatic test_cache();
    int rise0;
    bus.dev_ram_cs = 1'b1; bus.dev_ram_addr = 27'h200;
    tick(); tick();
    bus.sdram_ack = 1'b1; bus.sdram_rdata = 8'h33;
    tick();
    bus.sdram_ack = 1'b0;
    tick();
    checks++; if (bus.dev_ram_data !== 8'h33) begin failures++; $display("FAIL cache_fill got=%0h exp=33", bus.dev_ram_data); end
    bus.dev_ram_cs = 1'b0;
    tick(); tick();
    rise0 = rise_cnt;
    bus.dev_ram_cs = 1'b1;
    tick(); // N
    tick(); // N+1
    checks++; if (bus.dev_ram_valid !== 1'b1 || bus.dev_ram_data !== 8'h33) begin failures++; $display("FAIL cache_hit got=%0h/%0h exp=1/33", bus.dev_ram_valid, bus.dev_ram_data); end
    checks++; if (bus.sdram_req !== 1'b0 || bus.cpu_wait !== 1'b0) begin failures++; $display("FAIL cache_no_req got=%0h/%0h exp=0/0", bus.sdram_req, bus.cpu_wait); end
    tick();
    checks++; if (rise_cnt !== rise0) begin failures++; $display("FAIL cache_reads got=%0d exp=%0d", rise_cnt, rise0); end
    bus.dev_ram_cs = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_stray_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef DEVICE_RAM_CACHE_EN
    test_cache();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
